// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register bank port between external slave A (strict priority) and internal master B.
module reg_bus_arbiter #(
   parameter int AW = 2,
   parameter int DW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_wr,
   input  logic          a_rd,
   input  logic [AW-1:0] a_adr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_adr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          r_we,
   output logic          r_re,
   output logic [AW-1:0] r_adr,
   output logic [DW-1:0] r_wdata,
   input  logic [DW-1:0] r_rdata,
   output logic          err_collide
);
   typedef enum logic [1:0] {IDLE, A_ACC, B_ACC} state_t;
   state_t state, next;
   logic a_stb;
   logic q_we, q_re;
   logic [AW-1:0] q_adr;
   logic [DW-1:0] q_wdata;
   assign a_stb = a_wr | a_rd;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next  = a_stb ? A_ACC : b_req ? B_ACC : IDLE;
      b_gnt = !rst && next == B_ACC;
   end
   // Access fields are cleared whenever nothing is accepted, so the bank port idles at zero.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q_we        <= 1'b0;
         q_re        <= 1'b0;
         q_adr       <= '0;
         q_wdata     <= '0;
         a_rvalid    <= 1'b0;
         b_rvalid    <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         err_collide <= 1'b0;
      end else begin
         q_we        <= a_stb ? a_wr : b_req & b_we;
         q_re        <= a_stb ? a_rd & ~a_wr : b_req & ~b_we;
         q_adr       <= a_stb ? a_adr : b_req ? b_adr : '0;
         q_wdata     <= a_stb ? a_wdata : b_req ? b_wdata : '0;
         a_rvalid    <= state == A_ACC && q_re;
         b_rvalid    <= state == B_ACC && q_re;
         if (state == A_ACC && q_re) a_rdata <= r_rdata;
         if (state == B_ACC && q_re) b_rdata <= r_rdata;
         err_collide <= err_collide | (a_wr & a_rd);
      end
   assign r_we    = state != IDLE && q_we;
   assign r_re    = state != IDLE && q_re;
   assign r_adr   = state != IDLE ? q_adr : '0;
   assign r_wdata = state != IDLE ? q_wdata : '0;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed scenario tests for reg_bus_arbiter against a small register bank model.
module tb_reg_bus_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic a_wr = 0, a_rd = 0, b_req = 0, b_we = 0;
   logic [1:0] a_adr = 0, b_adr = 0;
   logic [2:0] a_wdata = 0, b_wdata = 0;
   logic a_rvalid, b_gnt, b_rvalid, r_we, r_re, err_collide;
   logic [2:0] a_rdata, b_rdata, r_wdata, r_rdata;
   logic [1:0] r_adr;
   logic [2:0] mem [4];
   logic ovr_en = 0;
   logic [2:0] ovr_val = 0;
   int tests = 0, fails = 0;

   reg_bus_arbiter #(.AW(2), .DW(3)) dut (
      .clk(clk), .rst(rst), .a_wr(a_wr), .a_rd(a_rd), .a_adr(a_adr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata), .b_req(b_req), .b_we(b_we), .b_adr(b_adr),
      .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .r_we(r_we),
      .r_re(r_re), .r_adr(r_adr), .r_wdata(r_wdata), .r_rdata(r_rdata), .err_collide(err_collide)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (r_we) mem[r_adr] <= r_wdata;
   assign r_rdata = ovr_en ? ovr_val : mem[r_adr];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step;
      step;
      tests++;
      if ({b_gnt, a_rvalid, b_rvalid, r_we, r_re, err_collide} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b want 000000", {b_gnt, a_rvalid, b_rvalid, r_we, r_re, err_collide});
      end
      tests++;
      if ({a_rdata, b_rdata, r_adr, r_wdata} !== 11'b0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0", {a_rdata, b_rdata, r_adr, r_wdata});
      end
      rst = 0;
   endtask

   task automatic test_write_read;
      a_wr = 1; a_adr = 1; a_wdata = 3'b101;
      #1;
      tests++;
      if (r_we !== 1'b0) begin fails++; $display("FAIL wr_T_rwe: got %b want 0", r_we); end
      step;
      a_wr = 0;
      #1;
      tests++;
      if ({r_we, r_re, r_adr, r_wdata} !== {1'b1, 1'b0, 2'd1, 3'b101}) begin
         fails++;
         $display("FAIL wr_T1_bank: got %b want 10_01_101", {r_we, r_re, r_adr, r_wdata});
      end
      step;
      tests++;
      if ({a_rvalid, r_we} !== 2'b00) begin fails++; $display("FAIL wr_T2_idle: got %b want 00", {a_rvalid, r_we}); end
      a_rd = 1; a_adr = 1;
      step;
      a_rd = 0;
      #1;
      tests++;
      if ({r_we, r_re, r_adr} !== {1'b0, 1'b1, 2'd1}) begin
         fails++;
         $display("FAIL rd_T1_bank: got %b want 0101", {r_we, r_re, r_adr});
      end
      step;
      tests++;
      if ({a_rvalid, a_rdata} !== {1'b1, 3'b101}) begin
         fails++;
         $display("FAIL rd_T2_rvalid: got %b want 1101", {a_rvalid, a_rdata});
      end
      step;
      tests++;
      if ({a_rvalid, a_rdata} !== {1'b0, 3'b101}) begin
         fails++;
         $display("FAIL rd_T3_hold: got %b want 0101", {a_rvalid, a_rdata});
      end
   endtask

   task automatic test_b_read;
      ovr_en = 1; ovr_val = 3'b100;
      b_req = 1; b_we = 0; b_adr = 2;
      #1;
      tests++;
      if (b_gnt !== 1'b1) begin fails++; $display("FAIL b_rd_gnt: got %b want 1", b_gnt); end
      step;
      b_req = 0;
      #1;
      tests++;
      if ({b_gnt, r_re, r_we, r_adr} !== {1'b0, 1'b1, 1'b0, 2'd2}) begin
         fails++;
         $display("FAIL b_rd_T1: got %b want 01010", {b_gnt, r_re, r_we, r_adr});
      end
      step;
      tests++;
      if ({b_rvalid, b_rdata, a_rvalid} !== {1'b1, 3'b100, 1'b0}) begin
         fails++;
         $display("FAIL b_rd_T2: got %b want 11000", {b_rvalid, b_rdata, a_rvalid});
      end
      ovr_en = 0;
      step;
      tests++;
      if (b_rvalid !== 1'b0) begin fails++; $display("FAIL b_rd_pulse: got %b want 0", b_rvalid); end
   endtask

   task automatic test_priority;
      a_rd = 1; a_adr = 1;
      b_req = 1; b_we = 1; b_adr = 0; b_wdata = 3'b011;
      #1;
      tests++;
      if (b_gnt !== 1'b0) begin fails++; $display("FAIL prio_no_gnt: got %b want 0", b_gnt); end
      step;
      a_rd = 0;
      #1;
      tests++;
      if ({b_gnt, r_re, r_adr} !== {1'b1, 1'b1, 2'd1}) begin
         fails++;
         $display("FAIL prio_a_first: got %b want 1101", {b_gnt, r_re, r_adr});
      end
      step;
      b_req = 0;
      #1;
      tests++;
      if ({r_we, r_adr, r_wdata, a_rvalid, a_rdata} !== {1'b1, 2'd0, 3'b011, 1'b1, 3'b101}) begin
         fails++;
         $display("FAIL prio_b_write: got %b want 1000111101", {r_we, r_adr, r_wdata, a_rvalid, a_rdata});
      end
      step;
      tests++;
      if (mem[0] !== 3'b011) begin fails++; $display("FAIL prio_bank0: got %b want 011", mem[0]); end
   endtask

   task automatic test_back_to_back;
      logic [5:0] exp;
      b_req = 1; b_we = 0; b_adr = 3;
      for (int i = 0; i < 4; i++) begin
         a_wr = 1; a_adr = 2'(i); a_wdata = 3'(i + 1);
         #1;
         tests++;
         if (b_gnt !== 1'b0) begin fails++; $display("FAIL b2b_gnt_%0d: got %b want 0", i, b_gnt); end
         if (i > 0) begin
            exp = {1'b1, 2'(i - 1), 3'(i)};
            tests++;
            if ({r_we, r_adr, r_wdata} !== exp) begin
               fails++;
               $display("FAIL b2b_issue_%0d: got %b want %b", i, {r_we, r_adr, r_wdata}, exp);
            end
         end
         step;
      end
      a_wr = 0;
      #1;
      tests++;
      if ({b_gnt, r_we, r_adr, r_wdata} !== {1'b1, 1'b1, 2'd3, 3'd4}) begin
         fails++;
         $display("FAIL b2b_cycle5: got %b want 1111100", {b_gnt, r_we, r_adr, r_wdata});
      end
      step;
      b_req = 0;
      #1;
      tests++;
      if ({r_re, r_adr} !== {1'b1, 2'd3}) begin fails++; $display("FAIL b2b_b_rd: got %b want 111", {r_re, r_adr}); end
      step;
      tests++;
      if ({b_rvalid, b_rdata} !== {1'b1, 3'd4}) begin
         fails++;
         $display("FAIL b2b_b_rdata: got %b want 1100", {b_rvalid, b_rdata});
      end
      b_req = 1; b_we = 1; b_adr = 2; b_wdata = 3'd6;
      #1;
      tests++;
      if (b_gnt !== 1'b1) begin fails++; $display("FAIL bheld_gnt0: got %b want 1", b_gnt); end
      step;
      tests++;
      if ({b_gnt, r_we, r_adr} !== {1'b1, 1'b1, 2'd2}) begin
         fails++;
         $display("FAIL bheld_gnt1: got %b want 1110", {b_gnt, r_we, r_adr});
      end
      step;
      b_req = 0;
      step;
   endtask

   task automatic test_collide;
      a_wr = 1; a_rd = 1; a_adr = 2; a_wdata = 3'd7;
      step;
      a_wr = 0; a_rd = 0;
      #1;
      tests++;
      if ({r_we, r_re, r_wdata, err_collide} !== {1'b1, 1'b0, 3'd7, 1'b1}) begin
         fails++;
         $display("FAIL coll_write: got %b want 101111", {r_we, r_re, r_wdata, err_collide});
      end
      step;
      tests++;
      if ({a_rvalid, err_collide} !== 2'b01) begin fails++; $display("FAIL coll_no_rvalid: got %b want 01", {a_rvalid, err_collide}); end
      step;
      step;
      tests++;
      if ({err_collide, mem[2]} !== {1'b1, 3'd7}) begin
         fails++;
         $display("FAIL coll_sticky: got %b want 1111", {err_collide, mem[2]});
      end
   endtask

   task automatic test_reset_abort;
      b_req = 1; b_we = 0; b_adr = 1;
      step;
      b_req = 0;
      #1;
      tests++;
      if (r_re !== 1'b1) begin fails++; $display("FAIL abort_pre: got %b want 1", r_re); end
      rst = 1;
      #1;
      tests++;
      if ({r_re, r_adr, err_collide, b_gnt} !== 5'b0) begin
         fails++;
         $display("FAIL abort_rst: got %b want 00000", {r_re, r_adr, err_collide, b_gnt});
      end
      step;
      rst = 0;
      step;
      tests++;
      if ({b_rvalid, b_rdata} !== 4'b0) begin fails++; $display("FAIL abort_no_rvalid: got %b want 0000", {b_rvalid, b_rdata}); end
      b_req = 1;
      #1;
      tests++;
      if (b_gnt !== 1'b1) begin fails++; $display("FAIL abort_regnt: got %b want 1", b_gnt); end
      step;
      b_req = 0;
      step;
      tests++;
      if ({b_rvalid, b_rdata} !== {1'b1, 3'd2}) begin
         fails++;
         $display("FAIL abort_reread: got %b want 1010", {b_rvalid, b_rdata});
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_b_read;
      test_priority;
      test_back_to_back;
      test_collide;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 2, register address width
- DW, 3, register data width
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on posedge clk
- rst  in  1  reset, asynchronous, active-high
- a_wr  in  1  port A (external bus slave) write strobe, one-cycle pulse
- a_rd  in  1  port A read strobe, one-cycle pulse
- a_adr  in  AW  port A address, valid with strobe
- a_wdata  in  DW  port A write data, valid with a_wr
- a_rvalid  out  1  port A read data valid, one-cycle pulse
- a_rdata  out  DW  port A read data, held until next A read completes
- b_req  in  1  port B (internal master) request level
- b_we  in  1  port B write (1) / read (0)
- b_adr  in  AW  port B address
- b_wdata  in  DW  port B write data
- b_gnt  out  1  port B accept pulse
- b_rvalid  out  1  port B read data valid, one-cycle pulse
- b_rdata  out  DW  port B read data, held until next B read completes
- r_we  out  1  register bank write enable
- r_re  out  1  register bank read strobe (for read side effects)
- r_adr  out  AW  register bank address
- r_wdata  out  DW  register bank write data
- r_rdata  in  DW  register bank read data, combinational from r_adr
- err_collide  out  1  sticky: a_wr and a_rd asserted together

Function
REQ-003 Block SHALL share one register bank port between A and B; A SHALL have strict priority and SHALL never be stalled or dropped.
REQ-004 State machine SHALL have states IDLE, A_ACC, B_ACC; next state evaluated every cycle: (a_wr|a_rd) -> A_ACC; else b_req -> B_ACC; else IDLE; A_ACC and B_ACC SHALL last exactly one cycle each.
REQ-005 On entry to A_ACC, A strobe, address and data SHALL be registered; r_adr/r_wdata/r_we/r_re SHALL be driven from those registers during A_ACC only.
REQ-006 On entry to B_ACC, b_gnt SHALL pulse high for one cycle in the cycle b_req is sampled and accepted, and B fields SHALL be registered that cycle.
REQ-007 b_req with b_adr/b_we/b_wdata SHALL be held stable by the master until b_gnt; block SHALL ignore b_req in any cycle where an A strobe is present (no b_gnt).
REQ-008 Simultaneous A strobe and b_req SHALL grant A; B SHALL be granted in the first subsequent cycle with no A strobe.
REQ-009 Back-to-back: A strobes on consecutive cycles SHALL be issued on consecutive cycles; B held high with no A SHALL be granted every cycle.
REQ-010 r_we/r_re SHALL be 0 in IDLE; r_adr/r_wdata SHALL be 0 in IDLE.
REQ-011 Read latency: strobe/grant cycle T, bank access cycle T+1, r_rdata captured at end of T+1 into a_rdata/b_rdata; a_rvalid/b_rvalid SHALL pulse in cycle T+2.
REQ-012 Writes SHALL produce no rvalid; a write occurs in bank at end of T+1.
REQ-013 a_wr and a_rd together SHALL be treated as a write and SHALL set err_collide, which stays 1 until rst.
REQ-014 At most one bank access per cycle; r_we and r_re SHALL never be high together.

Reset
REQ-015 While rst high: state IDLE; b_gnt, a_rvalid, b_rvalid, r_we, r_re, err_collide = 0; a_rdata, b_rdata, r_adr, r_wdata = 0.
REQ-016 rst asserted mid-access SHALL abort the in-flight access; no rvalid SHALL be produced for it; first request after rst release is arbitrated normally.

Verification
REQ-017 A write adr 1 data 3'b101, then A read adr 1 -> r_we at T+1 with r_adr=1; a_rvalid at read T+2 with a_rdata=3'b101.
REQ-018 b_req read adr 2 with bank returning 3'b100, no A traffic -> b_gnt same cycle, r_re next cycle, b_rvalid two cycles after grant with b_rdata=3'b100.
REQ-019 a_rd and b_req (write adr 0 data 3'b011) same cycle -> A issued first, b_gnt one cycle later, bank write of 3'b011 to adr 0 follows A read.
REQ-020 A strobes on 4 consecutive cycles with b_req held -> no b_gnt during those cycles, b_gnt in cycle 5, all 4 A accesses issued in order.
REQ-021 a_wr and a_rd together -> write performed, no a_rvalid, err_collide=1 and held until rst.
REQ-022 rst pulsed in cycle T+1 of a B read -> no b_rvalid, all outputs 0, subsequent B read completes normally.
